// File: rtl/score_keeper_pkg.sv
// Shared widths, state encodings and the double-dabble digit correction
// used by score_keeper and its BCD conversion engine.
package score_pkg;

    localparam int SCORE_W    = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic {
        PLAY,
        OVER
    } game_state_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // Add-3 correction applied to each digit before every shift.
    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/score_keeper_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock.
// A start in IDLE or DONE loads bin; done is high for the single DONE cycle.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W+SCORE_W-1:0] shifted;
    logic               load;

    // DONE can accept a new start directly so a pending reload loses no cycle.
    assign load = start && (state_q != SHIFT);

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj[4*i +: 4] = dabble(bcd_q[4*i +: 4]);
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = SHIFT;
            bin_d   = bin;
            bcd_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    bcd_d = shifted[BCD_W+SCORE_W-1:SCORE_W];
                    bin_d = shifted[SCORE_W-1:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_keeper.sv
// Snake score counter with play/over FSM and BCD mirror of the score.
// Define SCORE_KEEPER_HISCORE_EN to build the session high-score register.
module score_keeper
    import score_pkg::*;
#(
    parameter int PTS_PER_FRUIT = 1,
    parameter int SCORE_MAX     = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               eat_evt,
    input  logic               game_over,
    input  logic               restart,
    output logic [SCORE_W-1:0] outscore,
    output logic [SCORE_W-1:0] hiscore,
    output logic               game_active,
    output logic [BCD_W-1:0]   bcd_score,
    output logic               bcd_valid
);

    localparam logic [SCORE_W:0] PTS_W = (SCORE_W + 1)'(PTS_PER_FRUIT);
    localparam logic [SCORE_W:0] MAX_W = (SCORE_W + 1)'(SCORE_MAX);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               eat_prev_q, go_prev_q;
    logic               chg_q, pending_q, pending_d;
    logic [BCD_W-1:0]   bcd_score_q, bcd_score_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               eat_rise, go_rise;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] inc;
    logic               conv_start, conv_busy, conv_done, conv_accept;
    logic [BCD_W-1:0]   conv_bcd;

    assign eat_rise = eat_evt && !eat_prev_q;
    assign go_rise  = game_over && !go_prev_q;
    assign sum      = {1'b0, score_q} + PTS_W;
    assign inc      = eat_rise ? ((sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0])
                               : score_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        if (restart) begin
            state_d = PLAY;
            score_d = '0;
        end else if (state_q == PLAY) begin
            score_d = inc;
            if (go_rise) state_d = OVER;
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    logic [SCORE_W-1:0] hi_q, hi_d;

    // Compare against the post-increment value so a same-cycle eat counts.
    always_comb begin
        hi_d = hi_q;
        if (!restart && state_q == PLAY && go_rise && inc > hi_q) hi_d = inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hi_q <= '0;
        else        hi_q <= hi_d;
    end

    assign hiscore = hi_q;
`else
    assign hiscore = '0;
`endif

    // A change seen while mid-shift is parked in pending and reloaded at DONE.
    assign conv_accept = !conv_busy || conv_done;
    assign conv_start  = (chg_q || pending_q) && conv_accept;

    always_comb begin
        pending_d   = pending_q;
        bcd_valid_d = bcd_valid_q;
        bcd_score_d = bcd_score_q;
        if (conv_start) begin
            pending_d   = 1'b0;
            bcd_valid_d = 1'b0;
        end else begin
            if (chg_q) pending_d = 1'b1;
            if (conv_done) begin
                bcd_valid_d = 1'b1;
                bcd_score_d = conv_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLAY;
            score_q     <= '0;
            eat_prev_q  <= 1'b0;
            go_prev_q   <= 1'b0;
            chg_q       <= 1'b0;
            pending_q   <= 1'b0;
            bcd_score_q <= '0;
            bcd_valid_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            eat_prev_q  <= eat_evt;
            go_prev_q   <= game_over;
            chg_q       <= (score_d != score_q);
            pending_q   <= pending_d;
            bcd_score_q <= bcd_score_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (score_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign outscore    = score_q;
    assign game_active = (state_q == PLAY);
    assign bcd_score   = bcd_score_q;
    assign bcd_valid   = bcd_valid_q;

endmodule
